// File: rtl/sw_config_injector_pkg.sv
// rtl/sw_config_injector_pkg.sv - shared SW_CONFIG packet layout, command word and injector state
// Purpose: single owner of the SW_CONFIG bus packet format used by the injector and the switches.
package sw_config_injector_pkg;

    localparam int CNT_W  = 3;
    localparam int PORT_W = 2;
    localparam int SRC_W  = 4;

    // One packet on the daisy chain; count is the remaining hop distance.
    typedef struct packed {
        logic              valid;
        logic [CNT_W-1:0]  count;
        logic              enable;
        logic [PORT_W-1:0] port_num;
        logic [SRC_W-1:0]  src;
    } sw_config_t;

    // Host command as held in the command FIFO.
    typedef struct packed {
        logic              bcast;
        logic              enable;
        logic [SRC_W-1:0]  src;
        logic [PORT_W-1:0] port;
        logic [CNT_W-1:0]  hop;
    } cfg_cmd_t;

    localparam int CMD_W = $bits(cfg_cmd_t);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BCAST = 1'b1
    } inj_state_t;

endpackage

// File: rtl/sw_config_injector_fifo.sv
// rtl/sw_config_injector_fifo.sv - synchronous command FIFO for the config injector
// Purpose: power-of-2 deep FIFO with show-ahead head output.
// Ports: clk, rst_n (async active-low), i_push/i_data write side, i_pop read side,
//        o_head current head entry, o_full, o_empty.
module sw_cfg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/sw_config_injector.sv
// rtl/sw_config_injector.sv - head-end transmitter for the daisy-chained SW_CONFIG bus
// Purpose: buffers host config commands and emits SW_CONFIG packets (single hop or broadcast),
//          tracks packets in flight and pulses done when the furthest target has latched.
// Ports: clk, rst_n (async active-low); i_cmd_* host command with o_cmd_ready handshake;
//        o_sw_config_out registered packet into hop 0; o_busy, o_done pulse, o_err_hop sticky.
module sw_config_injector
    import sw_config_injector_pkg::*;
#(
    parameter int NUM_HOPS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [CNT_W-1:0]  i_cmd_hop,
    input  logic [PORT_W-1:0] i_cmd_port,
    input  logic [SRC_W-1:0]  i_cmd_src,
    input  logic              i_cmd_enable,
    input  logic              i_cmd_bcast,
    output sw_config_t        o_sw_config_out,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_hop
);

    localparam logic [CNT_W:0]   LP_HOPS   = (CNT_W+1)'(NUM_HOPS);
    localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(NUM_HOPS - 1);
    localparam logic [CNT_W-1:0] LP_BCAST2 = CNT_W'(NUM_HOPS - 2);

    cfg_cmd_t          w_cmd_in;
    cfg_cmd_t          w_head;
    logic [CMD_W-1:0]  w_head_bits;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_bad_hop;
    sw_config_t        w_pkt;
    logic              w_busy;
    logic [CNT_W:0]    w_drain_dec;
    logic [CNT_W:0]    w_drain_need;

    inj_state_t        r_state;
    logic [CNT_W-1:0]  r_idx;
    logic              r_en;
    logic [PORT_W-1:0] r_port;
    logic [SRC_W-1:0]  r_src;
    sw_config_t        r_out;
    logic              r_err_hop;
    logic [CNT_W:0]    r_drain;
    logic              r_busy_q;

    assign w_cmd_in    = {i_cmd_bcast, i_cmd_enable, i_cmd_src, i_cmd_port, i_cmd_hop};
    assign o_cmd_ready = ~w_full;
    assign w_push      = i_cmd_valid & ~w_full;
    assign w_head      = cfg_cmd_t'(w_head_bits);

    sw_cfg_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_head  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next packet to drive onto the bus; all-zero when nothing is emitted.
    always_comb begin
        w_pkt     = '0;
        w_pop     = 1'b0;
        w_bad_hop = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head.bcast) begin
                        w_pkt.valid = 1'b1;
                        w_pkt.count = LP_LAST;
                    end else if ({1'b0, w_head.hop} < LP_HOPS) begin
                        w_pkt.valid = 1'b1;
                        w_pkt.count = w_head.hop;
                    end else begin
                        w_bad_hop = 1'b1;
                    end
                    if (w_pkt.valid) begin
                        w_pkt.enable   = w_head.enable;
                        w_pkt.port_num = w_head.port;
                        w_pkt.src      = w_head.src;
                    end
                end
            end
            ST_BCAST: begin
                w_pkt.valid    = 1'b1;
                w_pkt.count    = r_idx;
                w_pkt.enable   = r_en;
                w_pkt.port_num = r_port;
                w_pkt.src      = r_src;
            end
            default: begin
                w_pkt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_en      <= 1'b0;
            r_port    <= '0;
            r_src     <= '0;
            r_out     <= '0;
            r_err_hop <= 1'b0;
        end else begin
            r_out <= w_pkt;
            if (w_bad_hop) begin
                r_err_hop <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    // A one-hop chain finishes the broadcast with the first packet.
                    if (w_pop && w_head.bcast && (NUM_HOPS > 1)) begin
                        r_state <= ST_BCAST;
                        r_idx   <= LP_BCAST2;
                        r_en    <= w_head.enable;
                        r_port  <= w_head.port;
                        r_src   <= w_head.src;
                    end
                end
                ST_BCAST: begin
                    r_idx <= r_idx - CNT_W'(1);
                    if (r_idx == '0) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // drain counts cycles until the furthest in-flight packet has been latched:
    // a packet for hop h is latched h+1 edges after it is registered here.
    assign w_drain_dec  = (r_drain == '0) ? '0 : (r_drain - (CNT_W+1)'(1));
    assign w_drain_need = {1'b0, w_pkt.count} + (CNT_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain  <= '0;
            r_busy_q <= 1'b0;
        end else begin
            if (w_pkt.valid && (w_drain_need > w_drain_dec)) begin
                r_drain <= w_drain_need;
            end else begin
                r_drain <= w_drain_dec;
            end
            r_busy_q <= w_busy;
        end
    end

    assign w_busy          = ~w_empty | (r_state == ST_BCAST) | r_out.valid | (r_drain != '0);
    assign o_busy          = w_busy;
    assign o_done          = r_busy_q & ~w_busy;
    assign o_sw_config_out = r_out;
    assign o_err_hop       = r_err_hop;

endmodule

// File: tb/tb_sw_config_injector.sv
// tb/tb_sw_config_injector.sv - scoreboard bench: injector driving a modelled 4-switch chain
module tb_sw_config_injector;
    import sw_config_injector_pkg::*;

    localparam int NUM_HOPS   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int NPORT      = 1 << PORT_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [CNT_W-1:0]  cmd_hop = '0;
    logic [PORT_W-1:0] cmd_port = '0;
    logic [SRC_W-1:0]  cmd_src = '0;
    logic              cmd_enable = 1'b0;
    logic              cmd_bcast = 1'b0;
    sw_config_t        dut_out;
    logic              busy;
    logic              done;
    logic              err_hop;

    always #5 clk = ~clk;

    sw_config_injector #(
        .NUM_HOPS   (NUM_HOPS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_cmd_valid     (cmd_valid),
        .o_cmd_ready     (cmd_ready),
        .i_cmd_hop       (cmd_hop),
        .i_cmd_port      (cmd_port),
        .i_cmd_src       (cmd_src),
        .i_cmd_enable    (cmd_enable),
        .i_cmd_bcast     (cmd_bcast),
        .o_sw_config_out (dut_out),
        .o_busy          (busy),
        .o_done          (done),
        .o_err_hop       (err_hop)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    sw_config_t       exp_q[$];
    logic [SRC_W-1:0] exp_store [NUM_HOPS][NPORT];
    logic             exp_en    [NUM_HOPS][NPORT];
    bit               exp_err = 0;
    int               done_cnt = 0;
    int               done_cyc = -1;
    int               valid_cnt = 0;
    int               run_len = 0;
    int               max_run = 0;
    bit               saw_stall = 0;

    // Switch chain model: each hop latches when count==0, otherwise forwards count-1.
    sw_config_t       link      [NUM_HOPS];
    logic [SRC_W-1:0] sw_store  [NUM_HOPS][NPORT];
    logic             sw_en     [NUM_HOPS][NPORT];
    int               latch_cyc [NUM_HOPS];
    sw_config_t       pin_v;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic sw_config_t mk(input int h, input logic en,
                                      input logic [PORT_W-1:0] p, input logic [SRC_W-1:0] s);
        sw_config_t c;
        c.valid    = 1'b1;
        c.count    = CNT_W'(h);
        c.enable   = en;
        c.port_num = p;
        c.src      = s;
        return c;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_HOPS; k++) begin
                link[k] <= '0;
                for (int p = 0; p < NPORT; p++) begin
                    sw_store[k][p] <= '0;
                    sw_en[k][p]    <= 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < NUM_HOPS; k++) begin
                pin_v = (k == 0) ? dut_out : link[k-1];
                if (pin_v.valid && pin_v.count == 0) begin
                    sw_store[k][pin_v.port_num] <= pin_v.src;
                    sw_en[k][pin_v.port_num]    <= pin_v.enable;
                    latch_cyc[k]                <= cyc;
                    link[k]                     <= '0;
                end else if (pin_v.valid) begin
                    link[k]       <= pin_v;
                    link[k].count <= pin_v.count - CNT_W'(1);
                end else begin
                    link[k] <= '0;
                end
            end
        end
    end

    // Scoreboard producer: a command seen valid&ready here is accepted at the coming edge.
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            if (cmd_bcast) begin
                for (int h = NUM_HOPS - 1; h >= 0; h--) begin
                    exp_q.push_back(mk(h, cmd_enable, cmd_port, cmd_src));
                    exp_store[h][cmd_port] = cmd_src;
                    exp_en[h][cmd_port]    = cmd_enable;
                end
            end else if (int'(cmd_hop) < NUM_HOPS) begin
                exp_q.push_back(mk(int'(cmd_hop), cmd_enable, cmd_port, cmd_src));
                exp_store[cmd_hop][cmd_port] = cmd_src;
                exp_en[cmd_hop][cmd_port]    = cmd_enable;
            end else begin
                exp_err = 1'b1;
            end
        end
    end

    // Monitor: every valid packet must be the next expected one; idle bus is all-zero.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dut_out.valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_pkt", longint'(dut_out), 0);
                end else begin
                    sw_config_t e;
                    e = exp_q.pop_front();
                    chk(dut_out == e, "pkt", longint'(dut_out), longint'(e));
                end
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                chk(dut_out == '0, "idle_word_zero", longint'(dut_out), 0);
                run_len = 0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send(input int hop, input int port, input int src, input int en,
                        input int bc, output int t_acc);
        bit ok;
        ok         = 1'b0;
        t_acc      = -1;
        cmd_hop    = CNT_W'(hop);
        cmd_port   = PORT_W'(port);
        cmd_src    = SRC_W'(src);
        cmd_enable = en[0];
        cmd_bcast  = bc[0];
        cmd_valid  = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                t_acc = cyc;
                ok    = 1'b1;
                break;
            end
            saw_stall = 1'b1;
        end
        if (!ok) chk(1'b0, "accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(1'b0, "idle_timeout", longint'(exp_q.size()), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cfg(input string tag);
        for (int h = 0; h < NUM_HOPS; h++) begin
            for (int p = 0; p < NPORT; p++) begin
                chk(sw_store[h][p] == exp_store[h][p] && sw_en[h][p] == exp_en[h][p],
                    $sformatf("%s_cfg_h%0d_p%0d", tag, h, p),
                    longint'({sw_en[h][p], sw_store[h][p]}),
                    longint'({exp_en[h][p], exp_store[h][p]}));
            end
        end
    endtask

    task automatic clear_model();
        for (int h = 0; h < NUM_HOPS; h++) begin
            for (int p = 0; p < NPORT; p++) begin
                exp_store[h][p] = '0;
                exp_en[h][p]    = 1'b0;
            end
        end
    endtask

    initial begin
        int t;
        int d0;
        int v0;
        bit found;
        sw_config_t e2;

        clear_model();

        // 1: reset state
        repeat (3) @(negedge clk);
        chk(dut_out == '0, "rst_out", longint'(dut_out), 0);
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(done == 1'b0, "rst_done", done, 0);
        chk(err_hop == 1'b0, "rst_err", err_hop, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk(cmd_ready == 1'b1, "rst_ready", cmd_ready, 1);
        chk(done == 1'b0, "rst_release_done", done, 0);
        @(posedge clk);
        #1;

        // 2: single hop 0, exact latency and done timing
        send(0, 2, 1, 1, 0, t);
        e2 = mk(0, 1'b1, 2'd2, 4'd1);
        @(negedge clk);
        chk(dut_out.valid == 1'b0, "t2_no_pkt_T1", dut_out.valid, 0);
        @(negedge clk);
        chk(dut_out == e2, "t2_pkt_T2", longint'(dut_out), longint'(e2));
        @(negedge clk);
        chk(done == 1'b1, "t2_done_T3", done, 1);
        chk(dut_out.valid == 1'b0, "t2_single_cycle", dut_out.valid, 0);
        chk(latch_cyc[0] == t + 2, "t2_latch_cycle", latch_cyc[0], t + 2);
        chk(sw_store[0][2] == 4'd1 && sw_en[0][2] == 1'b1, "t2_sw0_cfg",
            {sw_en[0][2], sw_store[0][2]}, 5'h11);
        wait_idle();

        // 3: broadcast, contiguous descending packets, done after last hop latches
        d0      = done_cnt;
        max_run = 0;
        send(0, 3, 0, 1, 1, t);
        wait_idle();
        chk(max_run == NUM_HOPS, "t3_contiguous", max_run, NUM_HOPS);
        chk(done_cnt == d0 + 1, "t3_done_count", done_cnt, d0 + 1);
        chk(done_cyc == latch_cyc[NUM_HOPS-1] + 1, "t3_done_timing", done_cyc,
            latch_cyc[NUM_HOPS-1] + 1);
        chk_cfg("t3");

        // 4: illegal hop is dropped and flagged; next command unaffected
        send(NUM_HOPS, 1, 5, 1, 0, t);
        repeat (4) @(negedge clk);
        chk(err_hop == 1'b1, "t4_err_set", err_hop, 1);
        @(posedge clk);
        #1;
        send(2, 1, 7, 0, 0, t);
        wait_idle();
        chk(err_hop == 1'b1, "t4_err_sticky", err_hop, 1);
        chk_cfg("t4");

        // 5: back-pressure with a broadcast followed by back-to-back singles
        saw_stall = 1'b0;
        max_run   = 0;
        send(0, 1, 9, 1, 1, t);
        send(0, 0, 3, 1, 0, t);
        send(1, 2, 4, 0, 0, t);
        send(2, 3, 5, 1, 0, t);
        send(3, 0, 6, 1, 0, t);
        send(1, 1, 8, 1, 0, t);
        chk(saw_stall == 1'b1, "t5_ready_dropped", saw_stall, 1);
        wait_idle();
        chk(max_run == NUM_HOPS + 5, "t5_one_per_cycle", max_run, NUM_HOPS + 5);
        chk_cfg("t5");

        // randomized traffic against the scoreboard
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send($urandom_range(0, NUM_HOPS), $urandom_range(0, NPORT - 1),
                 $urandom_range(0, 15), $urandom_range(0, 1),
                 ($urandom_range(0, 99) < 20) ? 1 : 0, t);
        end
        wait_idle();
        chk(err_hop == exp_err, "rand_err", err_hop, exp_err);
        chk_cfg("rand");

        // 6: reset during the second packet of a broadcast
        send(0, 2, 3, 1, 1, t);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (dut_out.valid && dut_out.count == CNT_W'(NUM_HOPS - 2)) begin
                found = 1'b1;
                break;
            end
        end
        chk(found, "t6_second_pkt_seen", found, 1);
        rst_n = 1'b0;
        #1;
        chk(dut_out == '0, "t6_out_cleared", longint'(dut_out), 0);
        chk(busy == 1'b0, "t6_busy_cleared", busy, 0);
        chk(done == 1'b0, "t6_no_done_in_reset", done, 0);
        exp_q.delete();
        clear_model();
        exp_err = 1'b0;
        d0      = done_cnt;
        v0      = valid_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk(valid_cnt == v0, "t6_no_more_pkts", valid_cnt, v0);
        chk(done_cnt == d0, "t6_no_done", done_cnt, d0);
        chk(busy == 1'b0, "t6_idle", busy, 0);
        chk(err_hop == 1'b0, "t6_err_cleared", err_hop, 0);
        chk(cmd_ready == 1'b1, "t6_ready", cmd_ready, 1);
        chk_cfg("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
